// File: rtl/btn_pkg.sv
// Shared command encoding between the button encoder and the LED pattern block.
package btn_pkg;

    localparam int unsigned N_BTN_DEF = 4;

    localparam logic [3:0] CMD_NONE = 4'b0000;
    localparam logic [3:0] CMD_B0   = 4'b0001;
    localparam logic [3:0] CMD_B1   = 4'b0010;
    localparam logic [3:0] CMD_B2   = 4'b0100;
    localparam logic [3:0] CMD_B3   = 4'b1000;

endpackage

// File: rtl/btn_debounce.sv
// Single-bit button conditioner: 2-flop synchronizer, debounce counter, stable level.
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   i_raw     asynchronous raw button level
//   o_stable  debounced level, changes only after DB_CNT consecutive disagreeing cycles
module btn_debounce #(
    parameter int unsigned DB_CNT = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_stable
);

    localparam int unsigned CNT_W = $clog2(DB_CNT + 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;

    // Any cycle of agreement restarts the count; the counter stops at DB_CNT-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DB_CNT - 1)) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_stable = r_stable;

endmodule

// File: rtl/button_cmd_encoder.sv
// Turns raw bouncing push-buttons into a held one-hot command vector.
// Build option: define BTN_TOGGLE_OFF_EN so re-pressing the active button clears the command.
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   btn_raw     asynchronous raw button levels, 1 = pressed
//   but         held command, one-hot or all-zero
//   but_pulse   one-cycle one-hot strobe of the accepted press
//   btn_stable  debounced button levels
module button_cmd_encoder
    import btn_pkg::*;
#(
    parameter int unsigned N_BTN  = N_BTN_DEF,
    parameter int unsigned DB_CNT = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] but,
    output logic [N_BTN-1:0] but_pulse,
    output logic [N_BTN-1:0] btn_stable
);

    logic [N_BTN-1:0] w_stable;
    logic [N_BTN-1:0] w_rise;
    logic [N_BTN-1:0] w_winner;
    logic [N_BTN-1:0] r_stable_q;
    logic [N_BTN-1:0] r_but;
    logic [N_BTN-1:0] r_pulse;

    // One conditioner per button.
    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        btn_debounce #(
            .DB_CNT (DB_CNT)
        ) u_db (
            .clk      (clk),
            .rst      (rst),
            .i_raw    (btn_raw[g]),
            .o_stable (w_stable[g])
        );
    end

    // Presses only; releases are ignored.
    assign w_rise = w_stable & ~r_stable_q;

    // Isolate the lowest set bit: bit 0 wins, other simultaneous rises are dropped.
    assign w_winner = w_rise & (~w_rise + N_BTN'(1));

    // Edge history and command register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stable_q <= '0;
            r_but      <= '0;
            r_pulse    <= '0;
        end else begin
            r_stable_q <= w_stable;
            r_pulse    <= w_winner;
            if (w_winner != '0) begin
`ifdef BTN_TOGGLE_OFF_EN
                r_but <= (w_winner == r_but) ? '0 : w_winner;
`else
                r_but <= w_winner;
`endif
            end
        end
    end

    assign but        = r_but;
    assign but_pulse  = r_pulse;
    assign btn_stable = w_stable;

endmodule

// File: doc/button_cmd_encoder.md
Name: button_cmd_encoder

Overview:
- Input-side companion to the LED pattern block: turns four raw, bouncing board push-buttons into the clean, one-hot, level-held 4-bit command vector (`but`) that the LED pattern block consumes.
- Pipeline per button: 2-flop synchronizer, then debounce filter, then rising-edge detect.
- A priority selector then latches the winning press into a held command register.
- Sits between board pins and the LED pattern block, in the same clock domain.

Parameters:
- N_BTN, 4, number of buttons; the command vector width.
- DB_CNT, 1000000, number of consecutive cycles a synchronized input must differ from its stable value before being accepted (10 ms at 100 MHz). Benches override this to 8.
- CNT_W, $clog2(DB_CNT+1), debounce counter width (derived).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- btn_raw  input  N_BTN  asynchronous raw button levels, 1 = pressed.
- but  output  N_BTN  held command: one-hot or all-zero; drives the LED pattern block.
- but_pulse  output  N_BTN  one-cycle, one-hot strobe marking the accepted press.
- btn_stable  output  N_BTN  debounced button levels, for status/debug.

Behaviour:
- Clock and reset: one clock, `clk`. Reset is synchronous and active-high on `rst`.
- Reset (rst=1 at an edge) clears all of the following:
  - synchronizer flops, debounce counters, btn_stable, edge-history register;
  - but = 0000 and but_pulse = 0000.
  - Every output reads 0 on the edge where rst is sampled high.
- Synchronizer: per bit, sync1 <= btn_raw, then sync2 <= sync1.
- Debounce, per bit:
  - If sync2 == btn_stable: cnt <= 0.
  - Else if cnt == DB_CNT-1: btn_stable <= sync2 and cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any single-cycle agreement with btn_stable restarts the count from 0.
- Latency: a raw change sampled at edge k (and held) appears on btn_stable at edge k+2+DB_CNT.
- Edge detect:
  - stable_q <= btn_stable.
  - rise = btn_stable & ~stable_q (combinational).
  - Releases (falling edges) are ignored.
- Selection:
  - If rise != 0, the winner is the lowest-index set bit of rise (bit 0 has highest priority).
  - All other simultaneous rises are discarded, not queued.
- Registered outputs at the edge after btn_stable rises (edge k+3+DB_CNT):
  - but_pulse <= one-hot winner for exactly one cycle, otherwise 0000.
  - but <= one-hot winner, except as modified by TOGGLE_OFF_EN below.
- Hold: `but` holds its value indefinitely with no press, including after the button is released.
- Invariant: `but` and `but_pulse` are never multi-hot.
- Button held through reset: btn_stable restarts at 0, so the held button is accepted as a new press DB_CNT+3 cycles after rst deasserts.
- Reset mid-debounce: the count in progress is lost and no pulse is produced.
- Counter saturation: cnt never exceeds DB_CNT-1, so there is no wrap-around.

Optional Feature:
- Macro: BTN_TOGGLE_OFF_EN.
- Defined: accepting a press of the button already active in `but` clears but to 0000. but_pulse still strobes that bit. This gives the "all off" command.
- Undefined: pressing the already-active button leaves but unchanged; but_pulse still strobes. The only way to reach 0000 after reset is rst.

Decomposition:
- Shared package `btn_pkg`:
  - N_BTN_DEF = 4;
  - CMD_NONE = 4'b0000;
  - one-hot command constants CMD_B0..CMD_B3 (0001, 0010, 0100, 1000), shared with the LED pattern block.
- Sub-module `btn_debounce`: single-bit synchronizer, debounce counter and stable register, parameterized by DB_CNT. Instantiated N_BTN times via generate.
- Priority select, edge detect and the command register stay in the top module.

Test Plan (DB_CNT=8, 10 ns clock):
- Held through reset: btn_raw=0001 held, rst=1 for 10 cycles then 0.
  - During reset: but=0000 and but_pulse=0000.
  - Exactly 11 cycles after deassertion: but_pulse=0001 for one cycle and but=0001.
- Glitch rejection: btn_raw[1] high for 5 cycles, then low.
  - btn_stable, but and but_pulse remain unchanged; no pulse.
- Clean press: btn_raw=0010 for 20 cycles, then 0000.
  - One pulse 0010, 11 cycles after assertion; but=0010 and stays 0010 after release.
- Simultaneous press: btn_raw 0000 → 1100 on one edge, held 20 cycles.
  - but=0100 and a single pulse 0100; bit 3 is never reported.
- Bounce then re-press: btn_raw[3] toggled 1/0/1/0/1 on consecutive cycles, then held 20 cycles.
  - Exactly one pulse 1000; but=1000.
  - Release, then re-press bit 3: with BTN_TOGGLE_OFF_EN, but=0000; without it, but=1000. Pulse 1000 in both builds.
